// File: rtl/uinstr_dispatch_if.sv
// Micro-instruction payload type and the dispatch bus interface.
// Optional stall counter port enabled by UINSTR_DISP_STALL_CNT_EN.
package config_pkg;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    typedef struct packed {
        logic [3:0]    op;
        logic [AW-1:0] vrs1;
        logic [AW-1:0] vrs2;
        logic [AW-1:0] vrs3;
    } uinstr_t;
endpackage

interface uinstr_dispatch_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    config_pkg::uinstr_t             in_uinstr_i;
    logic                            in_valid_i;
    logic                            in_ready_o;
    config_pkg::uinstr_t             out_uinstr_o;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic                            wb_valid_i;
    logic [config_pkg::AW-1:0]       wb_addr_i;
    logic                            flush_i;
    logic [CNT_W-1:0]                count_o;
    logic [config_pkg::NREG-1:0]     busy_o;
`ifdef UINSTR_DISP_STALL_CNT_EN
    logic [31:0]                     stall_cnt_o;
`endif

    // Dispatch unit side
    modport slave (
        input  in_uinstr_i, in_valid_i, out_ready_i, wb_valid_i, wb_addr_i, flush_i,
        output in_ready_o, out_uinstr_o, out_valid_o, count_o, busy_o
`ifdef UINSTR_DISP_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );

    // Decoder / controller side
    modport master (
        output in_uinstr_i, in_valid_i, out_ready_i, wb_valid_i, wb_addr_i, flush_i,
        input  in_ready_o, out_uinstr_o, out_valid_o, count_o, busy_o
`ifdef UINSTR_DISP_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/uinstr_dispatch.sv
// In-order micro-instruction dispatch FIFO with a vector-register busy scoreboard.
// Define UINSTR_DISP_STALL_CNT_EN to add a saturating hazard-stall counter.
module uinstr_dispatch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    uinstr_dispatch_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned NREG  = config_pkg::NREG;

    config_pkg::uinstr_t mem [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NREG-1:0]     busy_q, busy_d;

    config_pkg::uinstr_t head;
    logic                empty, full, hazard, head_ok, push, pop;

    // Hazard check uses the registered scoreboard only, so a writeback unblocks one cycle later
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr_q];
    assign hazard  = !empty && (busy_q[head.vrs1] || busy_q[head.vrs2] || busy_q[head.vrs3]);
    assign head_ok = !empty && !hazard;
    assign push    = bus.in_valid_i && !full && !bus.flush_i;
    assign pop     = head_ok && bus.out_ready_i && !bus.flush_i;

    always_comb begin
        count_d = count_q;
        if (bus.flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Issue-set is applied after writeback-clear so it wins on the same register
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid_i) begin
            busy_d[bus.wb_addr_i] = 1'b0;
        end
        if (pop) begin
            busy_d[head.vrs3] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            if (bus.flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Payload storage needs no reset; the count qualifies every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_uinstr_i;
        end
    end

    assign bus.in_ready_o   = !full;
    assign bus.out_valid_o  = head_ok;
    assign bus.out_uinstr_o = empty ? '0 : head;
    assign bus.count_o      = count_q;
    assign bus.busy_o       = busy_q;

`ifdef UINSTR_DISP_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_q <= '0;
        end else if (bus.flush_i) begin
            stall_q <= '0;
        end else if (hazard && (stall_q != '1)) begin
            stall_q <= stall_q + 32'(1);
        end
    end

    assign bus.stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_uinstr_dispatch.sv
// Self-checking bench for uinstr_dispatch: queue/scoreboard reference model plus directed scenarios.
module tb_uinstr_dispatch;
    import config_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk_i   = 1'b0;
    logic arst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    uinstr_dispatch_if #(.DEPTH(DEPTH)) bus ();
    uinstr_dispatch #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .arst_ni(arst_ni), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Reference model: a queue of pending instructions and a per-register pending flag
    uinstr_t q_m[$];
    bit      busy_m[32];
    longint  stall_m = 0;
    int      cyc = 0;

    uinstr_t iss_q[$];
    int      iss_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input uinstr_t u);
        return busy_m[u.vrs1] || busy_m[u.vrs2] || busy_m[u.vrs3];
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = busy_m[i];
        return v;
    endfunction

    function automatic uinstr_t mk(input logic [3:0] op, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [4:0] d);
        uinstr_t u;
        u.op = op; u.vrs1 = s1; u.vrs2 = s2; u.vrs3 = d;
        return u;
    endfunction

    always @(posedge clk_i or negedge arst_ni) begin : model
        bit can_issue, do_issue, do_push;
        if (!arst_ni) begin
            q_m.delete();
            for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
            stall_m = 0;
        end else begin
            cyc++;
            can_issue = (q_m.size() != 0) && !blocked(q_m[0]);
            do_issue  = can_issue && bus.out_ready_i && !bus.flush_i;
            do_push   = bus.in_valid_i && (q_m.size() < DEPTH) && !bus.flush_i;
            if (bus.flush_i) stall_m = 0;
            else if ((q_m.size() != 0) && !can_issue && stall_m < 64'hFFFF_FFFF) stall_m++;
            if (bus.wb_valid_i) busy_m[bus.wb_addr_i] = 1'b0;
            if (do_issue) begin
                busy_m[q_m[0].vrs3] = 1'b1;
                q_m.delete(0);
            end
            if (bus.flush_i) q_m.delete();
            else if (do_push) q_m.push_back(bus.in_uinstr_i);
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk_i) begin : compare
        bit exp_valid;
        if (started) begin
            exp_valid = (q_m.size() != 0) && !blocked(q_m[0]);
            chk("in_ready", 64'(bus.in_ready_o), 64'(q_m.size() < DEPTH));
            chk("count", 64'(bus.count_o), 64'(q_m.size()));
            chk("busy", 64'(bus.busy_o), 64'(busy_vec()));
            chk("out_valid", 64'(bus.out_valid_o), 64'(exp_valid));
            if (exp_valid) chk("out_uinstr", 64'(bus.out_uinstr_o), 64'(q_m[0]));
`ifdef UINSTR_DISP_STALL_CNT_EN
            chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(stall_m));
`endif
            if (arst_ni && bus.out_valid_o && bus.out_ready_i && !bus.flush_i) begin
                iss_q.push_back(bus.out_uinstr_o);
                iss_cyc.push_back(cyc + 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push1(input uinstr_t u);
        bus.in_uinstr_i = u;
        bus.in_valid_i  = 1'b1;
        step(1);
        bus.in_valid_i  = 1'b0;
    endtask

    task automatic wb1(input logic [4:0] a);
        bus.wb_valid_i = 1'b1;
        bus.wb_addr_i  = a;
        step(1);
        bus.wb_valid_i = 1'b0;
    endtask

    task automatic clr_log();
        iss_q.delete();
        iss_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_uinstr_i = '0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.wb_valid_i  = 1'b0;
        bus.wb_addr_i   = '0;
        bus.flush_i     = 1'b0;
        #2 arst_ni = 1'b0;
        started = 1'b1;
        step(3);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_uinstr", 64'(bus.out_uinstr_o), 64'd0);
        arst_ni = 1'b1;
        step(1);

        // 1: four independent instructions issue back to back
        clr_log();
        bus.out_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_uinstr_i = mk(4'(i), 5'd10, 5'd11, 5'(i));
            bus.in_valid_i  = 1'b1;
            step(1);
        end
        bus.in_valid_i = 1'b0;
        step(3);
        bus.out_ready_i = 1'b0;
        chk("t1_n_issued", 64'(iss_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < iss_q.size(); i++)
            chk("t1_order", 64'(iss_q[i].vrs3), 64'(i + 1));
        for (int i = 1; i < 4 && i < iss_cyc.size(); i++)
            chk("t1_consecutive", 64'(iss_cyc[i] - iss_cyc[i-1]), 64'd1);
        chk("t1_busy", 64'(bus.busy_o), 64'h1E);
        for (int i = 1; i <= 4; i++) wb1(5'(i));
        chk("t1_busy_clr", 64'(bus.busy_o), 64'd0);

        // 2: fill with controller stalled, fifth push rejected
        for (int i = 0; i < 5; i++) begin
            bus.in_uinstr_i = mk(4'd0, 5'd10, 5'd11, 5'(5 + i));
            bus.in_valid_i  = 1'b1;
            step(1);
        end
        bus.in_valid_i = 1'b0;
        chk("t2_count_full", 64'(bus.count_o), 64'd4);
        chk("t2_in_ready", 64'(bus.in_ready_o), 64'd0);
        clr_log();
        bus.out_ready_i = 1'b1;
        step(8);
        bus.out_ready_i = 1'b0;
        chk("t2_n_issued", 64'(iss_q.size()), 64'd4);
        if (iss_q.size() == 4) chk("t2_last", 64'(iss_q[3].vrs3), 64'd8);
        chk("t2_count_empty", 64'(bus.count_o), 64'd0);
        for (int i = 5; i <= 8; i++) wb1(5'(i));

        // 3: RAW hazard on v7 held until writeback
        bus.out_ready_i = 1'b1;
        push1(mk(4'd1, 5'd10, 5'd11, 5'd7));
        step(1);
        bus.out_ready_i = 1'b0;
        push1(mk(4'd2, 5'd7, 5'd11, 5'd13));
        step(3);
        chk("t3_blocked", 64'(bus.out_valid_o), 64'd0);
        chk("t3_busy7", 64'(bus.busy_o[7]), 64'd1);
        wb1(5'd7);
        chk("t3_unblocked", 64'(bus.out_valid_o), 64'd1);
        chk("t3_busy7_clr", 64'(bus.busy_o[7]), 64'd0);
        bus.out_ready_i = 1'b1;
        step(1);
        bus.out_ready_i = 1'b0;
        chk("t3_busy_after", 64'(bus.busy_o), 64'(32'h1 << 13));
        chk("t3_count", 64'(bus.count_o), 64'd0);
        wb1(5'd13);

        // 4: flush drops queue but keeps scoreboard
        bus.out_ready_i = 1'b1;
        push1(mk(4'd3, 5'd10, 5'd11, 5'd14));
        step(1);
        bus.out_ready_i = 1'b0;
        for (int i = 15; i <= 17; i++) push1(mk(4'd3, 5'd10, 5'd11, 5'(i)));
        chk("t4_count3", 64'(bus.count_o), 64'd3);
        clr_log();
        bus.flush_i     = 1'b1;
        bus.out_ready_i = 1'b1;
        step(1);
        bus.flush_i = 1'b0;
        chk("t4_count0", 64'(bus.count_o), 64'd0);
        chk("t4_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t4_busy", 64'(bus.busy_o), 64'(32'h1 << 14));
        step(2);
        bus.out_ready_i = 1'b0;
        chk("t4_no_issue", 64'(iss_q.size()), 64'd0);
        wb1(5'd14);
        chk("t4_busy_clr", 64'(bus.busy_o), 64'd0);

        // 5: simultaneous push and issue, writeback to idle register
        push1(mk(4'd4, 5'd10, 5'd11, 5'd18));
        push1(mk(4'd4, 5'd10, 5'd11, 5'd19));
        chk("t5_count2", 64'(bus.count_o), 64'd2);
        bus.in_uinstr_i = mk(4'd4, 5'd10, 5'd11, 5'd20);
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        step(1);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        chk("t5_count_same", 64'(bus.count_o), 64'd2);
        chk("t5_busy", 64'(bus.busy_o), 64'(32'h1 << 18));
        wb1(5'd25);
        chk("t5_busy_wb_idle", 64'(bus.busy_o), 64'(32'h1 << 18));
        bus.out_ready_i = 1'b1;
        step(3);
        bus.out_ready_i = 1'b0;
        for (int i = 18; i <= 20; i++) wb1(5'(i));
        chk("t5_busy_clr", 64'(bus.busy_o), 64'd0);

        // 6: sustained hazard, then asynchronous reset mid-stall
        bus.out_ready_i = 1'b1;
        push1(mk(4'd5, 5'd10, 5'd11, 5'd21));
        step(1);
        bus.out_ready_i = 1'b0;
        bus.flush_i = 1'b1;
        step(1);
        bus.flush_i = 1'b0;
`ifdef UINSTR_DISP_STALL_CNT_EN
        chk("t6_stall0", 64'(bus.stall_cnt_o), 64'd0);
`endif
        push1(mk(4'd6, 5'd21, 5'd11, 5'd22));
        step(10);
`ifdef UINSTR_DISP_STALL_CNT_EN
        chk("t6_stall10", 64'(bus.stall_cnt_o), 64'd10);
`endif
        chk("t6_pre_count", 64'(bus.count_o), 64'd1);
        @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1;
        chk("t6_rst_count", 64'(bus.count_o), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy_o), 64'd0);
        chk("t6_rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t6_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("t6_rst_uinstr", 64'(bus.out_uinstr_o), 64'd0);
`ifdef UINSTR_DISP_STALL_CNT_EN
        chk("t6_rst_stall", 64'(bus.stall_cnt_o), 64'd0);
`endif
        step(2);
        arst_ni = 1'b1;
        step(2);
        chk("t6_post_count", 64'(bus.count_o), 64'd0);
        chk("t6_post_busy", 64'(bus.busy_o), 64'd0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
